// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory for the IF stage: runtime program-load port plus a
// registered, stall-aware fetch port. Define IMEM_BOUNDS_CHECK_EN to fault illegal fetches.
module imem_fetch_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 64,
  parameter logic [XLEN-1:0] NOP_WORD    = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic            load_done,
  output logic            busy,
  input  logic            fetch_req,
  input  logic [31:0]     fetch_pc,
  input  logic            stall,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic            fetch_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            load_done_q, load_done_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic            mem_we;
  logic [AW-1:0]   fetch_idx;
  logic            fetch_illegal;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  assign fetch_idx = fetch_pc[AW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign fetch_illegal = (fetch_pc[1:0] != 2'b00) || (fetch_pc[31:AW+2] != '0);
`else
  // Without checking the address wraps, so the upper and byte-offset bits are don't-care.
  logic unused_pc;
  assign unused_pc     = ^{fetch_pc[31:AW+2], fetch_pc[1:0]};
  assign fetch_illegal = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    load_done_d = 1'b0;
    instr_d     = instr_q;
    valid_d     = valid_q;
    fault_d     = fault_q;
    mem_we      = 1'b0;
    load_ready  = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        fault_d = 1'b0;
        if (load_start) begin
          state_d = StLoad;
          ptr_d   = '0;
        end
      end
      StLoad: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        valid_d    = 1'b0;
        fault_d    = 1'b0;
        if (load_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + AW'(1);
          if (load_last || ptr_q == AW'(DEPTH_WORDS - 1)) begin
            state_d     = StRun;
            load_done_d = 1'b1;
          end
        end
      end
      StRun: begin
        // A reload request takes priority over any fetch issued in the same cycle.
        if (load_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else if (!stall) begin
          if (fetch_req) begin
            valid_d = 1'b1;
            fault_d = fetch_illegal;
            instr_d = fetch_illegal ? NOP_WORD : mem[fetch_idx];
          end else begin
            valid_d = 1'b0;
            fault_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      load_done_q <= 1'b0;
      instr_q     <= NOP_WORD;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_done_q <= load_done_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
    end
  end

  // Storage is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= load_data;
    end
  end

  assign load_done   = load_done_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed + randomized bench for imem_fetch_unit against a word-array reference model.
// Expectations follow IMEM_BOUNDS_CHECK_EN when the bench is built with it.
module tb_imem_fetch_unit;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk, rst_n;
  logic        load_start, load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready, load_done, busy;
  logic        fetch_req, stall;
  logic [31:0] fetch_pc;
  logic [31:0] instr;
  logic        instr_valid, fetch_fault;

  imem_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .busy        (busy),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_instr;
  logic        exp_valid, exp_fault;
  logic [31:0] words [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit pc_legal(input logic [31:0] pc);
`ifdef IMEM_BOUNDS_CHECK_EN
    return (pc % 4 == 0) && (pc < 4 * DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk_fetch(input string tag);
    chk({tag, "_instr"}, instr, exp_instr);
    chk({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, exp_valid});
    chk({tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, exp_fault});
  endtask

  // One RUN-state cycle: drive, clock, advance the reference model, compare.
  task automatic fetch_step(input logic req, input logic [31:0] pc, input logic st,
                            input string tag);
    fetch_req = req;
    fetch_pc  = pc;
    stall     = st;
    tick();
    if (!st) begin
      if (req) begin
        exp_valid = 1'b1;
        exp_fault = !pc_legal(pc);
        exp_instr = pc_legal(pc) ? model_mem[(pc >> 2) % DEPTH] : NOP;
      end else begin
        exp_valid = 1'b0;
        exp_fault = 1'b0;
      end
    end
    chk_fetch(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    chk({tag, "_ready"}, {31'd0, load_ready}, 32'd0);
    chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] pc, d;
    int ready_cycles, done_pulses;
    rst_n = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    fetch_req = 0; fetch_pc = '0; stall = 0;
    exp_instr = NOP; exp_valid = 0; exp_fault = 0;
    words[0] = 32'h00000013; words[1] = 32'h019806B3; words[2] = 32'h403402B3;
    for (int i = 3; i < 12; i++) words[i] = $urandom;

    #1 rst_n = 1'b0;
    #10;
    chk_reset_outputs("reset");
    tick();
    rst_n = 1'b1;

    // IDLE ignores fetches.
    fetch_req = 1'b1; fetch_pc = 32'd4;
    tick(); tick();
    chk("idle_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_instr", instr, NOP);
    fetch_req = 1'b0;

    // 12-word load terminated by load_last.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_busy", {31'd0, busy}, 32'd1);
    ready_cycles = 0; done_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      load_valid = 1'b1; load_data = words[i]; load_last = (i == 11);
      if (load_ready) ready_cycles++;
      if (load_done) done_pulses++;
      tick();
      model_mem[i] = words[i];
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("load_ready_cycles", ready_cycles, 12);
    chk("load_done_early", done_pulses, 0);
    chk("load_done_pulse", {31'd0, load_done}, 32'd1);
    chk("load_ready_drop", {31'd0, load_ready}, 32'd0);
    chk("load_busy_drop", {31'd0, busy}, 32'd0);

    // Back-to-back fetches, the first issued in the load_done cycle.
    fetch_step(1'b1, 32'd0, 1'b0, "f_pc0");
    chk("load_done_single", {31'd0, load_done}, 32'd0);
    fetch_step(1'b1, 32'd4, 1'b0, "f_pc4");
    fetch_step(1'b1, 32'd8, 1'b0, "f_pc8");

    // Stall holds the PC-8 result for three cycles.
    for (int i = 0; i < 3; i++) fetch_step(1'b1, 32'd12, 1'b1, "stall_hold");
    fetch_step(1'b1, 32'd12, 1'b0, "stall_release");
    fetch_step(1'b0, 32'd12, 1'b0, "no_req");

    // Boundary addresses.
    fetch_step(1'b1, 32'd6, 1'b0, "pc6");
    fetch_step(1'b1, 32'd256, 1'b0, "pc256");
    fetch_step(1'b1, 32'd256, 1'b1, "pc256_stall");
    fetch_step(1'b1, 32'd4, 1'b0, "after_bad");

    // Random traffic over the loaded words, with aliases and misaligned offsets.
    for (int i = 0; i < 60; i++) begin
      pc = 32'($urandom_range(0, 11)) * 4;
      if ($urandom_range(0, 3) == 0) pc = pc + 32'd256 * 32'($urandom_range(1, 1000));
      if ($urandom_range(0, 4) == 0) pc = pc + 32'($urandom_range(1, 3));
      fetch_step($urandom_range(0, 4) != 0, pc, $urandom_range(0, 4) == 0, "rand_a");
    end

    // Reload requested together with a fetch: the fetch is dropped.
    load_start = 1'b1; fetch_req = 1'b1; fetch_pc = 32'd4; stall = 1'b0;
    tick();
    load_start = 1'b0; fetch_req = 1'b0;
    exp_valid = 1'b0; exp_fault = 1'b0;
    chk("reload_valid", {31'd0, instr_valid}, 32'd0);
    chk("reload_busy", {31'd0, busy}, 32'd1);
    chk("reload_ready", {31'd0, load_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
      tick();
    end
    load_valid = 1'b0;

    // Asynchronous reset mid-load.
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    exp_instr = NOP; exp_valid = 0; exp_fault = 0;
    fetch_req = 1'b1; fetch_pc = 32'd0;
    tick();
    chk_reset_outputs("post_rst_idle");
    fetch_req = 1'b0;

    // Full-depth load ending on the last word without load_last; gaps carry a stray load_last.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 20 || i == 40) begin
        load_valid = 1'b0; load_last = 1'b1;
        tick();
        chk("gap_busy", {31'd0, busy}, 32'd1);
      end
      d = $urandom;
      load_valid = 1'b1; load_data = d; load_last = 1'b0;
      if (i == DEPTH - 1) chk("full_ready_last", {31'd0, load_ready}, 32'd1);
      tick();
      model_mem[i] = d;
    end
    load_valid = 1'b0;
    chk("full_done", {31'd0, load_done}, 32'd1);
    chk("full_ready_drop", {31'd0, load_ready}, 32'd0);
    chk("full_busy_drop", {31'd0, busy}, 32'd0);

    fetch_step(1'b1, 32'd252, 1'b0, "full_last_word");
    fetch_step(1'b1, 32'd256, 1'b0, "full_wrap");
    for (int i = 0; i < 80; i++) begin
      pc = 32'($urandom_range(0, DEPTH - 1)) * 4;
      if ($urandom_range(0, 3) == 0) pc = $urandom;
      fetch_step($urandom_range(0, 4) != 0, pc, $urandom_range(0, 5) == 0, "rand_b");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
